// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze/stop sequencer: one-cycle registered outputs, no backpressure (strobe/level driven).
// Define HOURLY_CHIME_EN to add the top-of-hour CHIME state (two 1 Hz ticks of steady 512 Hz).
module alarm_sequencer #(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_MINUTES = 5,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        tick_4hz,
  input  logic [23:0] time_bcd,
  input  logic [23:0] alarm_bcd,
  input  logic        alarm_on,
  input  logic        snooze,
  input  logic        stop,
  output logic        beep512_en,
  output logic        beep1k_en,
  output logic        ringing,
  output logic        snoozed
);

  localparam logic [7:0] RING_LAST   = 8'(RING_SECONDS - 1);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MINUTES * 60);
  localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

`ifdef HOURLY_CHIME_EN
  typedef enum logic [1:0] {IDLE, RING, SNOOZE, CHIME} state_t;
`else
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  ring_cnt_q, ring_cnt_d;
  logic [9:0]  cdown_q, cdown_d;
  logic [2:0]  snz_cnt_q, snz_cnt_d;
  logic        eq_q, armed_q, snooze_q, stop_q;
  logic        beep512_q, beep1k_q, ringing_q, snoozed_q;

  logic        time_eq, alarm_evt, snooze_edge, stop_edge;

  // The edge is taken on time equality alone so that re-enabling alarm_on while
  // the clock still sits on the alarm second does not ring; armed_q masks the
  // first cycle after reset so a match present at release cannot form an edge.
  assign time_eq     = (time_bcd == alarm_bcd);
  assign alarm_evt   = time_eq & ~eq_q & alarm_on & armed_q;
  assign snooze_edge = snooze & ~snooze_q;
  assign stop_edge   = stop & ~stop_q;

`ifdef HOURLY_CHIME_EN
  logic top_q, chime_cnt_q, chime_cnt_d, top_of_hour, chime_evt;
  assign top_of_hour = (time_bcd[15:0] == 16'h0000);
  assign chime_evt   = top_of_hour & ~top_q & armed_q;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    ring_cnt_d = ring_cnt_q;
    cdown_d    = cdown_q;
    snz_cnt_d  = snz_cnt_q;
`ifdef HOURLY_CHIME_EN
    chime_cnt_d = chime_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (alarm_evt) begin
          state_d    = RING;
          phase_d    = 2'd0;
          ring_cnt_d = 8'd0;
          snz_cnt_d  = 3'd0;
        end
`ifdef HOURLY_CHIME_EN
        else if (chime_evt) begin
          state_d     = CHIME;
          chime_cnt_d = 1'b0;
        end
`endif
      end
      RING: begin
        if (!alarm_on || stop_edge) begin
          state_d = IDLE;
        end else if (snooze_edge) begin
          if (snz_cnt_q < SNOOZE_MAX) begin
            state_d   = SNOOZE;
            snz_cnt_d = snz_cnt_q + 3'd1;
            cdown_d   = SNOOZE_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else if (tick_1hz && (ring_cnt_q >= RING_LAST)) begin
          state_d = IDLE;
        end else begin
          if (tick_1hz && (ring_cnt_q != 8'hFF)) ring_cnt_d = ring_cnt_q + 8'd1;
          if (tick_4hz) phase_d = phase_q + 2'd1;
        end
      end
      SNOOZE: begin
        if (!alarm_on || stop_edge) begin
          state_d = IDLE;
        end else if (tick_1hz) begin
          if (cdown_q <= 10'd1) begin
            state_d    = RING;
            cdown_d    = 10'd0;
            ring_cnt_d = 8'd0;
            phase_d    = 2'd0;
          end else begin
            cdown_d = cdown_q - 10'd1;
          end
        end
      end
`ifdef HOURLY_CHIME_EN
      CHIME: begin
        // The chime ignores alarm_on; only a real alarm event or stop cuts it short.
        if (alarm_evt) begin
          state_d    = RING;
          phase_d    = 2'd0;
          ring_cnt_d = 8'd0;
          snz_cnt_d  = 3'd0;
        end else if (stop_edge) begin
          state_d = IDLE;
        end else if (tick_1hz) begin
          if (chime_cnt_q) state_d = IDLE;
          else             chime_cnt_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      phase_q    <= 2'd0;
      ring_cnt_q <= 8'd0;
      cdown_q    <= 10'd0;
      snz_cnt_q  <= 3'd0;
      eq_q       <= 1'b0;
      armed_q    <= 1'b0;
      snooze_q   <= 1'b0;
      stop_q     <= 1'b0;
      beep512_q  <= 1'b0;
      beep1k_q   <= 1'b0;
      ringing_q  <= 1'b0;
      snoozed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      ring_cnt_q <= ring_cnt_d;
      cdown_q    <= cdown_d;
      snz_cnt_q  <= snz_cnt_d;
      eq_q       <= time_eq;
      armed_q    <= 1'b1;
      snooze_q   <= snooze;
      stop_q     <= stop;
      ringing_q  <= (state_d == RING);
      snoozed_q  <= (state_d == SNOOZE);
      beep1k_q   <= (state_d == RING) && (phase_d == 2'd0);
`ifdef HOURLY_CHIME_EN
      beep512_q  <= ((state_d == RING) && (phase_d == 2'd1)) || (state_d == CHIME);
`else
      beep512_q  <= (state_d == RING) && (phase_d == 2'd1);
`endif
    end
  end

`ifdef HOURLY_CHIME_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q       <= 1'b0;
      chime_cnt_q <= 1'b0;
    end else begin
      top_q       <= top_of_hour;
      chime_cnt_q <= chime_cnt_d;
    end
  end
`endif

  assign beep512_en = beep512_q;
  assign beep1k_en  = beep1k_q;
  assign ringing    = ringing_q;
  assign snoozed    = snoozed_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with RING_SECONDS=4, SNOOZE_MINUTES=1, MAX_SNOOZE=2.
// Output vector under check is {ringing, snoozed, beep1k_en, beep512_en}.
module tb_alarm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_1hz = 1'b0, tick_4hz = 1'b0;
  logic [23:0] time_bcd = 24'h072959, alarm_bcd = 24'h073000;
  logic        alarm_on = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic        beep512_en, beep1k_en, ringing, snoozed;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alarm_sequencer #(.RING_SECONDS(4), .SNOOZE_MINUTES(1), .MAX_SNOOZE(2)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_4hz(tick_4hz),
    .time_bcd(time_bcd), .alarm_bcd(alarm_bcd), .alarm_on(alarm_on),
    .snooze(snooze), .stop(stop), .beep512_en(beep512_en), .beep1k_en(beep1k_en),
    .ringing(ringing), .snoozed(snoozed)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  function automatic logic [3:0] outs();
    return {ringing, snoozed, beep1k_en, beep512_en};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_1hz();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic pulse_4hz();
    tick_4hz = 1'b1;
    step();
    tick_4hz = 1'b0;
  endtask

  task automatic ring_up();
    time_bcd = 24'h073001;
    step();
    time_bcd = 24'h073000;
    step();
  endtask

  initial begin
    step();
    step();
    check("reset_outs", outs(), 4'b0000);
    rst = 1'b1;
    alarm_on = 1'b1;
    step();
    check("idle_before_match", outs(), 4'b0000);

    // Basic ring, pattern, ignored re-event, timeout.
    time_bcd = 24'h073000;
    step();
    check("ring_entry", outs(), 4'b1010);
    time_bcd = 24'h073001;
    pulse_4hz();
    check("phase1_512", outs(), 4'b1001);
    pulse_4hz();
    check("phase2_off", outs(), 4'b1000);
    pulse_4hz();
    check("phase3_off", outs(), 4'b1000);
    pulse_4hz();
    check("phase_wrap_1k", outs(), 4'b1010);
    step();
    check("phase_hold", outs(), 4'b1010);
    for (int i = 1; i <= 3; i++) begin
      pulse_1hz();
      check($sformatf("ring_tick%0d", i), outs(), 4'b1010);
    end
    time_bcd = 24'h073000;
    step();
    check("event_in_ring_ignored", outs(), 4'b1010);
    pulse_1hz();
    check("ring_timeout", outs(), 4'b0000);
    step();
    check("no_reevent_after_timeout", outs(), 4'b0000);

    // Snooze cycle with limit; entry coincident with tick_4hz keeps phase 0.
    time_bcd = 24'h073001;
    step();
    time_bcd = 24'h073000;
    tick_4hz = 1'b1;
    step();
    tick_4hz = 1'b0;
    check("entry_phase0_with_tick4", outs(), 4'b1010);
    snooze = 1'b1;
    step();
    check("snooze1", outs(), 4'b0100);
    step();
    check("snooze_level_no_edge", outs(), 4'b0100);
    snooze = 1'b0;
    for (int i = 0; i < 59; i++) pulse_1hz();
    check("snooze_59_ticks", outs(), 4'b0100);
    pulse_1hz();
    check("snooze_expire_ring", outs(), 4'b1010);
    snooze = 1'b1;
    step();
    check("snooze2", outs(), 4'b0100);
    snooze = 1'b0;
    for (int i = 0; i < 60; i++) pulse_1hz();
    check("snooze2_expire_ring", outs(), 4'b1010);
    snooze = 1'b1;
    step();
    check("snooze_limit_stops", outs(), 4'b0000);
    snooze = 1'b0;
    step();

    // Stop and snooze together: stop wins.
    ring_up();
    check("ring_for_stop", outs(), 4'b1010);
    stop = 1'b1;
    snooze = 1'b1;
    step();
    check("stop_beats_snooze", outs(), 4'b0000);
    step();
    check("snoozed_stays_low", outs(), 4'b0000);
    stop = 1'b0;
    snooze = 1'b0;

    // alarm_on dropped in SNOOZE, then reasserted while time still equal.
    ring_up();
    snooze = 1'b1;
    step();
    check("snooze_before_off", outs(), 4'b0100);
    snooze = 1'b0;
    alarm_on = 1'b0;
    step();
    check("alarm_off_idle", outs(), 4'b0000);
    alarm_on = 1'b1;
    step();
    step();
    check("no_rering_on_reenable", outs(), 4'b0000);
    ring_up();
    check("next_edge_rings", outs(), 4'b1010);

    // Asynchronous reset mid-ring; release with time equal to alarm.
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_clear", outs(), 4'b0000);
    step();
    rst = 1'b1;
    step();
    check("release_match_no_ring", outs(), 4'b0000);
    step();
    check("release_match_still_idle", outs(), 4'b0000);

    // Stop in SNOOZE.
    ring_up();
    snooze = 1'b1;
    step();
    check("snooze_before_stop", outs(), 4'b0100);
    snooze = 1'b0;
    stop = 1'b1;
    step();
    check("stop_in_snooze", outs(), 4'b0000);
    stop = 1'b0;

    // Top of hour.
    alarm_on = 1'b0;
    time_bcd = 24'h075959;
    step();
    time_bcd = 24'h080000;
    step();
`ifdef HOURLY_CHIME_EN
    check("chime_start", outs(), 4'b0001);
    time_bcd = 24'h080001;
    pulse_1hz();
    check("chime_tick1", outs(), 4'b0001);
    pulse_1hz();
    check("chime_done", outs(), 4'b0000);
    alarm_bcd = 24'h080000;
    alarm_on = 1'b1;
    time_bcd = 24'h075959;
    step();
    time_bcd = 24'h080000;
    step();
    check("alarm_beats_chime", outs(), 4'b1010);
`else
    check("no_chime_default", outs(), 4'b0000);
    time_bcd = 24'h080001;
    pulse_1hz();
    check("no_chime_after_tick", outs(), 4'b0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
